// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side word packer.
// Holds the packer FSM state encoding and the native byte width.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        FETCH,
        CAPTURE,
        PRESENT
    } rx_pack_state_t;

endpackage

// File: rtl/uart_idle_timer.sv
// Saturating idle counter that flags a partial-word flush.
// Used by uart_rx_word_packer only when UART_RX_FLUSH_TIMEOUT_EN is defined.
module uart_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Holds at the limit so the flush stays requested until cleared.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
        end else if (run && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/uart_rx_word_packer.sv
// Pops RX FIFO bytes and packs them little-endian into valid/ready words.
// Define UART_RX_FLUSH_TIMEOUT_EN to flush partial words after an idle timeout.
module uart_rx_word_packer
    import uart_pkg::*;
#(
    parameter int FIFO_WIDTH     = UART_BYTE_W,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rx_empty,
    input  logic [FIFO_WIDTH-1:0]                read_data,
    output logic                                 ren,
    output logic [FIFO_WIDTH*BYTES_PER_WORD-1:0] word_data,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]  word_bytes,
    output logic                                 word_valid,
    input  logic                                 word_ready
);

    localparam int CW = $clog2(BYTES_PER_WORD + 1);
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);
    localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);

    rx_pack_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic           flush;

`ifdef UART_RX_FLUSH_TIMEOUT_EN
    logic expired;
    logic idle_run;
    logic idle_clr;

    assign idle_run = (state_q == FETCH) && rx_empty && (cnt_q != '0);
    assign idle_clr = ren || (word_valid && word_ready);
    assign flush    = expired && (state_q == FETCH) && (cnt_q != '0);

    uart_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (idle_run),
        .clr    (idle_clr),
        .expired(expired)
    );
`else
    assign flush = 1'b0;
`endif

    assign word_valid = (state_q == PRESENT);

    always_comb begin
        state_d = state_q;
        ren     = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (flush) begin
                    state_d = PRESENT;
                end else begin
                    ren = ~rx_empty;
                    if (!rx_empty) state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = (cnt_q == LAST) ? PRESENT : FETCH;
            end
            PRESENT: begin
                if (word_ready) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (!rst) ren = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FETCH;
            cnt_q      <= '0;
            word_data  <= '0;
            word_bytes <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                FETCH: begin
                    if (flush) word_bytes <= cnt_q;
                end
                CAPTURE: begin
                    word_data[int'(cnt_q)*FIFO_WIDTH +: FIFO_WIDTH] <= read_data;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) word_bytes <= FULL;
                end
                PRESENT: begin
                    if (word_ready) begin
                        cnt_q      <= '0;
                        word_data  <= '0;
                        word_bytes <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer with a FIFO model and word scoreboard.
// Honours UART_RX_FLUSH_TIMEOUT_EN for the partial-word flush scenario.
module tb_uart_rx_word_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  read_data = 8'h00;
    logic        ren;
    logic [31:0] word_data;
    logic [2:0]  word_bytes;
    logic        word_valid;
    logic        word_ready = 1'b0;

    uart_rx_word_packer #(
        .FIFO_WIDTH(8),
        .BYTES_PER_WORD(4),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .read_data (read_data),
        .ren       (ren),
        .word_data (word_data),
        .word_bytes(word_bytes),
        .word_valid(word_valid),
        .word_ready(word_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] nbytes;
    } exp_t;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] word;
    } vec_t;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    int ren_pulses = 0;
    int viol = 0;
    int hs_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [31:0] n);
        exp_t e;
        e.data = d;
        e.nbytes = n;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("drain_timeout", 32'(k >= budget), 32'd0);
    endtask

    // RX FIFO model: data appears the cycle after ren.
    initial begin
        logic ren_s;
        forever begin
            @(negedge clk);
            ren_s = ren;
            @(posedge clk);
            #1;
            if (ren_s) begin
                ren_pulses++;
                if (fifo_q.size() > 0) read_data = fifo_q.pop_front();
                else viol++;
            end
            rx_empty = (fifo_q.size() == 0);
        end
    end

    // Output monitor and scoreboard.
    initial begin
        logic        pv, phs, prst;
        logic [31:0] pd;
        logic [2:0]  pb;
        exp_t        e;
        pv = 0; phs = 0; prst = 0; pd = 0; pb = 0;
        forever begin
            @(negedge clk);
            if (ren && word_valid) viol++;
            if (!rst && ren) viol++;
            if (rst && prst && pv && !phs) begin
                if (!word_valid) viol++;
                else if (word_data !== pd || word_bytes !== pb) viol++;
            end
            if (rst && word_valid && word_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", word_data, 32'hxxxxxxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", word_data, e.data);
                    check("word_bytes", 32'(word_bytes), e.nbytes);
                end
            end
            pv = word_valid;
            phs = word_valid && word_ready;
            prst = rst;
            pd = word_data;
            pb = word_bytes;
        end
    end

    vec_t vecs[4];

    initial begin
        int r0, h0, k, nz;
        vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
        vecs[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};
        vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 32'hFF00FF00};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 8'hFE, 32'hFE7F0180};

        repeat (3) @(negedge clk);
        check("rst_ren", 32'(ren), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_data", word_data, 32'd0);
        check("rst_bytes", 32'(word_bytes), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;

        nz = 0;
        repeat (100) begin
            @(negedge clk);
            if (ren || word_valid || word_data != 0 || word_bytes != 0) nz++;
        end
        check("idle_outputs", 32'(nz), 32'd0);

        @(posedge clk); #2;
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r0 = ren_pulses;
            push_byte(vecs[i].b0);
            push_byte(vecs[i].b1);
            push_byte(vecs[i].b2);
            push_byte(vecs[i].b3);
            expect_word(vecs[i].word, 4);
            drain(200);
            check("vec_ren_pulses", 32'(ren_pulses - r0), 32'd4);
        end

        @(posedge clk); #2;
        word_ready = 1'b0;
        r0 = ren_pulses;
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        expect_word(32'h04030201, 4);
        expect_word(32'h08070605, 4);
        repeat (30) @(negedge clk);
        check("bp_valid_held", 32'(word_valid), 32'd1);
        check("bp_data_stable", word_data, 32'h04030201);
        check("bp_ren_stalled", 32'(ren_pulses - r0), 32'd4);
        @(posedge clk); #2;
        word_ready = 1'b1;
        drain(300);
        check("bp_total_pops", 32'(ren_pulses - r0), 32'd8);

        @(posedge clk); #2;
        word_ready = 1'b0;
        push_byte(8'h10); push_byte(8'h20); push_byte(8'h30);
        push_byte(8'h40); push_byte(8'h50);
        expect_word(32'h40302010, 4);
        expect_word(32'h80706050, 4);
        k = 0;
        while (!word_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("b2b_valid_timeout", 32'(k >= 100), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        word_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b2b_ren_next", 32'(ren), 32'd1);
        push_byte(8'h60); push_byte(8'h70); push_byte(8'h80);
        drain(300);

        r0 = ren_pulses;
        push_byte(8'hA1); push_byte(8'hA2);
        k = 0;
        while (ren_pulses - r0 < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("partial_pop_timeout", 32'(k >= 100), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(word_valid), 32'd0);
        check("midrst_data", word_data, 32'd0);
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
        expect_word(32'h04030201, 4);
        drain(300);

        h0 = hs_cnt;
        push_byte(8'hAA); push_byte(8'hBB);
`ifdef UART_RX_FLUSH_TIMEOUT_EN
        expect_word(32'h0000BBAA, 2);
        drain(1300);
        check("flush_words", 32'(hs_cnt - h0), 32'd1);
`else
        repeat (1100) @(negedge clk);
        check("noflush_words", 32'(hs_cnt - h0), 32'd0);
        check("noflush_valid", 32'(word_valid), 32'd0);
`endif
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        check("protocol_violations", 32'(viol), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
